// File: rtl/vector_load_unit.sv
// vector_load_unit
// Gathers VECTOR_SIZE elements from memory, one read request at a time, into
// an element buffer and then writes the whole buffer to a vector register in
// a single cycle.
//
// Build option: define VLOAD_STRIDE_EN to add the `stride` port and allow
// strided loads. With the macro undefined the port is absent and every load
// is unit-stride.
//
// All outputs are registers. The element buffer drives wd directly, so wd
// always shows the most recently gathered data (all-zero after reset).
module vector_load_unit #(
  parameter int WIDTH        = 16,
  parameter int VECTOR_SIZE  = 16,
  parameter int NUM_VECTORES = 16,
  parameter int ADDR_WIDTH   = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [$clog2(NUM_VECTORES)-1:0] vdst,
  input  logic [ADDR_WIDTH-1:0]           base_addr,
`ifdef VLOAD_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0]           stride,
`endif
  output logic                            busy,
  output logic                            done,
  output logic                            mem_req,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  input  logic                            mem_ack,
  input  logic [WIDTH-1:0]                mem_rdata,
  output logic                            we3,
  output logic [$clog2(NUM_VECTORES)-1:0] v3,
  output logic [WIDTH-1:0]                wd [VECTOR_SIZE-1:0]
);

  localparam int VW    = $clog2(NUM_VECTORES);
  localparam int IDX_W = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VECTOR_SIZE - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t                state;
  logic [IDX_W-1:0]      idx;
  logic [VW-1:0]         vdst_q;
  logic [ADDR_WIDTH-1:0] step;

  // The base address is not kept separately: mem_addr itself is the running
  // address base + idx*step, advanced by one step per accepted beat. Modular
  // addition in ADDR_WIDTH bits gives the required wrap-around for free.
`ifdef VLOAD_STRIDE_EN
  logic [ADDR_WIDTH-1:0] stride_q;
  assign step = stride_q;
`else
  assign step = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
`endif

  // Load sequencer: latches the request, walks the element addresses,
  // captures read data into the buffer and issues the register-file write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= {IDX_W{1'b0}};
      vdst_q   <= {VW{1'b0}};
`ifdef VLOAD_STRIDE_EN
      stride_q <= {ADDR_WIDTH{1'b0}};
`endif
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= {ADDR_WIDTH{1'b0}};
      we3      <= 1'b0;
      v3       <= {VW{1'b0}};
      for (int i = 0; i < VECTOR_SIZE; i++) begin
        wd[i] <= {WIDTH{1'b0}};
      end
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          we3  <= 1'b0;
          if (start) begin
            // Latch the request; start is not looked at again until IDLE.
            state    <= FETCH;
            vdst_q   <= vdst;
`ifdef VLOAD_STRIDE_EN
            stride_q <= stride;
`endif
            idx      <= {IDX_W{1'b0}};
            busy     <= 1'b1;
            mem_req  <= 1'b1;
            mem_addr <= base_addr;
          end else begin
            busy    <= 1'b0;
            mem_req <= 1'b0;
          end
        end

        FETCH: begin
          // Request and address hold steady until the memory acknowledges.
          if (mem_ack) begin
            wd[idx] <= mem_rdata;
            if (idx == LAST_IDX) begin
              // Last element captured: present the write next cycle.
              state   <= WRITE;
              mem_req <= 1'b0;
              v3      <= vdst_q;
              done    <= 1'b1;
              // Register 0 is hardwired to zero, so suppress the write
              // but still report completion.
              we3     <= (vdst_q != {VW{1'b0}});
            end else begin
              idx      <= idx + IDX_ONE;
              mem_addr <= mem_addr + step;
            end
          end else begin
            mem_req <= 1'b1;
          end
        end

        WRITE: begin
          // Single write cycle, then back to IDLE ready for a new start.
          state   <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          we3     <= 1'b0;
          mem_req <= 1'b0;
        end

        default: begin
          // Unreachable encoding: recover to a quiet IDLE.
          state   <= IDLE;
          idx     <= {IDX_W{1'b0}};
          busy    <= 1'b0;
          done    <= 1'b0;
          we3     <= 1'b0;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_load_unit.sv
// Self-checking bench for vector_load_unit. A reference model computes each
// element address as (base + i*stride) mod 2^16 and each element's data from
// a per-load random key. It records which loads must produce a write and a
// done pulse, and compares the DUT cycle by cycle. Define VLOAD_STRIDE_EN for
// both RTL and bench to exercise strided loads.
module tb_vector_load_unit;

  localparam int W  = 16;
  localparam int VS = 16;
  localparam int NV = 16;
  localparam int AW = 16;
  localparam int VW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [VW-1:0] vdst;
  logic [AW-1:0] base_addr;
`ifdef VLOAD_STRIDE_EN
  logic [AW-1:0] stride;
`endif
  logic          busy;
  logic          done;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [W-1:0]  mem_rdata;
  logic          we3;
  logic [VW-1:0] v3;
  logic [W-1:0]  wd [VS-1:0];

  int checks = 0;
  int errors = 0;

  // Reference state: expected buffer contents and expected pulse totals.
  logic [W-1:0] exp_buf [VS];
  int exp_we3  = 0;
  int exp_done = 0;
  int we3_seen  = 0;
  int done_seen = 0;

  vector_load_unit #(
    .WIDTH(W), .VECTOR_SIZE(VS), .NUM_VECTORES(NV), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vdst(vdst), .base_addr(base_addr),
`ifdef VLOAD_STRIDE_EN
    .stride(stride),
`endif
    .busy(busy), .done(done), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .we3(we3), .v3(v3), .wd(wd)
  );

  always #5 clk = ~clk;

  // Count every we3 and done cycle, to catch extra or missing writes.
  always @(negedge clk) begin
    if (we3)  we3_seen++;
    if (done) done_seen++;
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Element i of a load lives at base + i*stride, modulo 2^16.
  function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] b,
                                                input logic [AW-1:0] s,
                                                input int i);
    int unsigned full;
    full = int'(b) + int'(s) * i;
    return full[AW-1:0];
  endfunction

  task automatic check_wd(input string tag);
    for (int i = 0; i < VS; i++) begin
      check16($sformatf("%s wd[%0d]", tag, i), wd[i], exp_buf[i]);
    end
  endtask

  // One complete load. Called at a negedge with the DUT idle; returns at a
  // negedge with the DUT idle again. ack_mode: 1 = ack every cycle,
  // 3 = ack every third cycle, 0 = random acks (at most 3 stalls per beat).
  // busy_start raises start with a different vdst in the middle of the load.
  task automatic run_load(input logic [VW-1:0] vd, input logic [AW-1:0] b,
                          input logic [AW-1:0] s, input int ack_mode,
                          input logic [W-1:0] key, input bit busy_start);
    logic [AW-1:0] s_eff;
    logic [AW-1:0] a;
    logic          ack;
    int            waits;
    int            cyc;
`ifdef VLOAD_STRIDE_EN
    s_eff = s;
`else
    s_eff = 16'd1;
`endif
    check1("idle busy", busy, 1'b0);
    start     = 1'b1;
    vdst      = vd;
    base_addr = b;
`ifdef VLOAD_STRIDE_EN
    stride    = s;
`endif
    mem_ack   = 1'b1;            // an ack while idle must be ignored
    mem_rdata = 16'($urandom());
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    for (int i = 0; i < VS; i++) begin
      a     = model_addr(b, s_eff, i);
      waits = 0;
      ack   = 1'b0;
      while (!ack) begin
        check1("fetch mem_req", mem_req, 1'b1);
        check16($sformatf("fetch mem_addr beat %0d", i), mem_addr, a);
        check1("fetch busy", busy, 1'b1);
        check1("fetch done", done, 1'b0);
        check1("fetch we3", we3, 1'b0);
        cyc++;
        if (busy_start && cyc == 3) begin
          start     = 1'b1;
          vdst      = vd ^ 4'd7;
          base_addr = ~b;
        end else begin
          start = 1'b0;
        end
        case (ack_mode)
          1:       ack = 1'b1;
          3:       ack = (waits == 2);
          default: ack = ($urandom_range(0, 1) == 1) || (waits >= 3);
        endcase
        if (ack) begin
          mem_ack    = 1'b1;
          mem_rdata  = a ^ key;
          exp_buf[i] = a ^ key;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 16'($urandom());
          waits++;
        end
        @(negedge clk);
      end
    end
    // WRITE cycle; an ack here must not be taken.
    start     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 16'($urandom());
    exp_done++;
    if (vd != 4'd0) exp_we3++;
    check1("write done", done, 1'b1);
    check1("write we3", we3, vd != 4'd0);
    check16("write v3", 16'(v3), 16'(vd));
    check1("write busy", busy, 1'b1);
    check1("write mem_req", mem_req, 1'b0);
    check_wd("write");
    @(negedge clk);
    mem_ack = 1'b0;
    check1("post busy", busy, 1'b0);
    check1("post done", done, 1'b0);
    check1("post we3", we3, 1'b0);
    check_wd("post");
  endtask

  initial begin
    logic [AW-1:0] ab_s;
    rst_n     = 1'b1;
    start     = 1'b0;
    vdst      = 4'd0;
    base_addr = 16'd0;
`ifdef VLOAD_STRIDE_EN
    stride    = 16'd0;
    ab_s      = 16'd3;
`else
    ab_s      = 16'd1;
`endif
    mem_ack   = 1'b0;
    mem_rdata = 16'd0;
    for (int i = 0; i < VS; i++) exp_buf[i] = 16'd0;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check1("reset busy", busy, 1'b0);
    check1("reset done", done, 1'b0);
    check1("reset mem_req", mem_req, 1'b0);
    check1("reset we3", we3, 1'b0);
    check16("reset mem_addr", mem_addr, 16'd0);
    check16("reset v3", 16'(v3), 16'd0);
    check_wd("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Unit stride, data = address, back-to-back with the next loads
    run_load(4'd3, 16'h0100, 16'd1, 1, 16'h0000, 1'b0);
    // Backpressure: ack every third cycle
    run_load(4'd7, 16'h0A00, 16'd1, 3, 16'($urandom()), 1'b0);
    // Address wrap-around (stride 4 when enabled, otherwise unit stride)
    run_load(4'd1, 16'hFFF8, 16'd4, 1, 16'($urandom()), 1'b0);
    // Hardwired-zero destination: done pulses, no write
    run_load(4'd0, 16'($urandom()), 16'($urandom()), 1, 16'($urandom()), 1'b0);
    // start with vdst=5 while a vdst=2 load is in progress
    run_load(4'd2, 16'h3000, 16'd2, 1, 16'($urandom()), 1'b1);

    // Abort: reset after 5 accepted beats
    start     = 1'b1;
    vdst      = 4'd9;
    base_addr = 16'h2000;
`ifdef VLOAD_STRIDE_EN
    stride    = ab_s;
`endif
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_ack   = 1'b1;
      mem_rdata = 16'($urandom());
      @(negedge clk);
    end
    mem_ack = 1'b0;
    check16("abort mem_addr before reset", mem_addr, model_addr(16'h2000, ab_s, 5));
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < VS; i++) exp_buf[i] = 16'd0;
    check1("abort busy", busy, 1'b0);
    check1("abort mem_req", mem_req, 1'b0);
    check1("abort done", done, 1'b0);
    check1("abort we3", we3, 1'b0);
    check16("abort mem_addr", mem_addr, 16'd0);
    check16("abort v3", 16'(v3), 16'd0);
    check_wd("abort");
    @(negedge clk);
    rst_n = 1'b1;
    // start on the first edge after reset release, restarting at element 0
    run_load(4'd9, 16'h2000, ab_s, 1, 16'($urandom()), 1'b0);

    // Randomized loads
    for (int n = 0; n < 6; n++) begin
      int mode_pick;
      mode_pick = $urandom_range(0, 2);
      run_load(4'($urandom()), 16'($urandom()), 16'($urandom()),
               (mode_pick == 0) ? 0 : ((mode_pick == 1) ? 1 : 3),
               16'($urandom()), 1'b0);
    end

    // Totals: exactly one done per load, a write only for nonzero vdst
    @(negedge clk);
    check32("total done pulses", done_seen, exp_done);
    check32("total we3 pulses", we3_seen, exp_we3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
